// File: rtl/imm_encoder.sv
// Immediate encoder: scatters a signed immediate into RISC-V I/S/B/J fields of a base word.
// Optional IMM_ENC_STRICT_ALIGN_EN flags B/J immediates with bit0 set as misaligned.
module imm_encoder #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_base,
   input  logic [1:0]       in_immcntrl,
   input  logic [31:0]      in_imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic             out_range_err,
   output logic             out_align_err,
   output logic [CNT_W-1:0] err_count
);

   typedef struct packed {
      logic [31:0] base;
      logic [1:0]  fmt;
      logic [20:0] imm;   // J reaches imm[20]; higher bits only matter to the range check
      logic        range_err;
      logic        align_err;
   } s1_t;

   // vld_pipe[0]: stage-1 holds an item, vld_pipe[1]: out_* holds an item
   logic [1:0]  vld_pipe;
   s1_t         s1, s1_nxt;
   logic [31:0] asm_instr;
   logic        s2_can_take;
   logic        xfer;

   assign out_valid   = vld_pipe[1];
   assign s2_can_take = !vld_pipe[1] || out_ready;
   assign in_ready    = !vld_pipe[0] || s2_can_take;
   assign xfer        = vld_pipe[1] && out_ready;

   always_comb begin
      s1_nxt.base      = in_base;
      s1_nxt.fmt       = in_immcntrl;
      s1_nxt.imm       = in_imm[20:0];
      s1_nxt.range_err = 1'b0;
      case (in_immcntrl)
         2'b00, 2'b01: s1_nxt.range_err = !((&in_imm[31:11]) || !(|in_imm[31:11]));
         2'b10:        s1_nxt.range_err = !((&in_imm[31:12]) || !(|in_imm[31:12]));
         default:      s1_nxt.range_err = !((&in_imm[31:20]) || !(|in_imm[31:20]));
      endcase
`ifdef IMM_ENC_STRICT_ALIGN_EN
      s1_nxt.align_err = in_immcntrl[1] && in_imm[0];
`else
      s1_nxt.align_err = 1'b0;
`endif
   end

   always_comb begin
      asm_instr = s1.base;
      case (s1.fmt)
         2'b00: asm_instr[31:20] = s1.imm[11:0];
         2'b01: begin
            asm_instr[31:25] = s1.imm[11:5];
            asm_instr[11:7]  = s1.imm[4:0];
         end
         2'b10: begin
            asm_instr[31]    = s1.imm[12];
            asm_instr[30:25] = s1.imm[10:5];
            asm_instr[11:8]  = s1.imm[4:1];
            asm_instr[7]     = s1.imm[11];
         end
         default: begin
            asm_instr[31]    = s1.imm[20];
            asm_instr[30:21] = s1.imm[10:1];
            asm_instr[20]    = s1.imm[11];
            asm_instr[19:12] = s1.imm[19:12];
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe      <= 2'b00;
         s1            <= '0;
         out_instr     <= '0;
         out_range_err <= 1'b0;
         out_align_err <= 1'b0;
         err_count     <= '0;
      end else begin
         if (s2_can_take) begin
            vld_pipe[1] <= vld_pipe[0];
            if (vld_pipe[0]) begin
               out_instr     <= asm_instr;
               out_range_err <= s1.range_err;
               out_align_err <= s1.align_err;
            end
         end
         if (in_ready) begin
            vld_pipe[0] <= in_valid;
            if (in_valid) s1 <= s1_nxt;
         end
         if (xfer && (out_range_err || out_align_err) && (err_count != {CNT_W{1'b1}}))
            err_count <= err_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule
